// File: rtl/sad_min_search.sv
// Accumulates per-row SAD for 8 candidates over ROWS rows, then scans them one per cycle for the minimum.
// done_o pulses 9 cycles after the last accepted row; valid_i is dropped while busy_o is high.
module sad_min_search #(
  parameter int ROWS = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [127:0] cand0_i,
  input  logic [127:0] cand1_i,
  input  logic [127:0] cand2_i,
  input  logic [127:0] cand3_i,
  input  logic [127:0] cand4_i,
  input  logic [127:0] cand5_i,
  input  logic [127:0] cand6_i,
  input  logic [127:0] cand7_i,
  input  logic [127:0] cur_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [2:0]   best_idx_o,
  output logic [15:0]  best_sad_o
);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_CMP   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

  logic [1:0]   state;
  logic [3:0]   row_cnt;
  logic [2:0]   cmp_idx;
  logic [15:0]  acc     [8];
  logic [127:0] cand    [8];
  logic [11:0]  row_sad [8];

  assign cand[0] = cand0_i;
  assign cand[1] = cand1_i;
  assign cand[2] = cand2_i;
  assign cand[3] = cand3_i;
  assign cand[4] = cand4_i;
  assign cand[5] = cand5_i;
  assign cand[6] = cand6_i;
  assign cand[7] = cand7_i;

  function automatic logic [11:0] row_sad_f(input logic [127:0] a, input logic [127:0] b);
    logic [11:0] sum;
    logic [7:0]  pa;
    logic [7:0]  pb;
    sum = '0;
    for (int k = 0; k < 16; k++) begin
      pa  = a[8*k +: 8];
      pb  = b[8*k +: 8];
      sum = sum + 12'((pa > pb) ? (pa - pb) : (pb - pa));
    end
    return sum;
  endfunction

  always_comb begin
    for (int c = 0; c < 8; c++) begin
      row_sad[c] = row_sad_f(cand[c], cur_i);
    end
  end

  assign busy_o = (state != ST_ACCUM);
  assign done_o = (state == ST_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_ACCUM;
      row_cnt    <= '0;
      cmp_idx    <= '0;
      best_idx_o <= '0;
      best_sad_o <= '0;
      for (int c = 0; c < 8; c++) begin
        acc[c] <= '0;
      end
    end else begin
      case (state)
        ST_ACCUM: begin
          if (valid_i) begin
            // 16 rows of at most 4080 each stay below 2^16, so no saturation is needed.
            for (int c = 0; c < 8; c++) begin
              acc[c] <= acc[c] + 16'(row_sad[c]);
            end
            if (row_cnt == ROW_LAST) begin
              state   <= ST_CMP;
              cmp_idx <= '0;
            end else begin
              row_cnt <= row_cnt + 4'd1;
            end
          end
        end
        ST_CMP: begin
          // Strict less-than keeps the lowest index on ties.
          if ((cmp_idx == 3'd0) || (acc[cmp_idx] < best_sad_o)) begin
            best_sad_o <= acc[cmp_idx];
            best_idx_o <= cmp_idx;
          end
          if (cmp_idx == 3'd7) begin
            state <= ST_DONE;
          end else begin
            cmp_idx <= cmp_idx + 3'd1;
          end
        end
        ST_DONE: begin
          state   <= ST_ACCUM;
          row_cnt <= '0;
          cmp_idx <= '0;
          for (int c = 0; c < 8; c++) begin
            acc[c] <= '0;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Directed bench for sad_min_search: hand-computed minimum SAD results, latency, busy window and reset abort.
module tb_sad_min_search;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [127:0] cur;
  logic [127:0] cand [8];
  logic         busy;
  logic         done;
  logic [2:0]   best_idx;
  logic [15:0]  best_sad;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sad_min_search #(.ROWS(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .cand0_i    (cand[0]),
    .cand1_i    (cand[1]),
    .cand2_i    (cand[2]),
    .cand3_i    (cand[3]),
    .cand4_i    (cand[4]),
    .cand5_i    (cand[5]),
    .cand6_i    (cand[6]),
    .cand7_i    (cand[7]),
    .cur_i      (cur),
    .busy_o     (busy),
    .done_o     (done),
    .best_idx_o (best_idx),
    .best_sad_o (best_sad)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // cb holds one byte per candidate, candidate c at bits [8c+7:8c]; every pixel of a row gets that byte.
  task automatic load(input logic [7:0] cur_b, input logic [63:0] cb);
    cur = {16{cur_b}};
    for (int c = 0; c < 8; c++) begin
      cand[c] = {16{cb[8*c +: 8]}};
    end
  endtask

  task automatic send_rows(input int n, input logic [7:0] cur_b, input logic [63:0] cb);
    for (int r = 0; r < n; r++) begin
      load(cur_b, cb);
      valid = 1'b1;
      tick();
      valid = 1'b0;
    end
  endtask

  // Entered one cycle after the last row was accepted; junk drives valid_i with poisonous rows while busy.
  task automatic finish_block(input string tag, input logic junk,
                              input logic [2:0] exp_idx, input logic [15:0] exp_sad);
    int lat;
    int busy_cyc;
    lat      = 1;
    busy_cyc = 0;
    if (junk) begin
      load(8'h00, {8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      valid = 1'b1;
    end
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cyc++;
      tick();
      lat++;
    end
    if (busy === 1'b1) busy_cyc++;
    check({tag, " latency"}, lat, 9);
    check({tag, " done"}, done, 1);
    check({tag, " best_idx"}, best_idx, exp_idx);
    check({tag, " best_sad"}, best_sad, exp_sad);
    tick();
    valid = 1'b0;
    check({tag, " done width"}, done, 0);
    check({tag, " busy falls"}, busy, 0);
    check({tag, " busy cycles"}, busy_cyc, 9);
    check({tag, " result held"}, best_sad, exp_sad);
  endtask

  initial begin
    int gaps [16] = '{0, 2, 1, 3, 0, 1, 2, 4, 0, 1, 1, 2, 3, 0, 2, 2};
    int busy_seen;
    int done_seen;

    rst   = 1'b1;
    valid = 1'b0;
    load(8'h00, 64'h0);
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset best_idx", best_idx, 0);
    check("reset best_sad", best_sad, 0);
    rst = 1'b0;
    tick();

    // Basic: cand3 matches the current block exactly.
    send_rows(16, 8'h10, {8'h20, 8'h20, 8'h20, 8'h20, 8'h10, 8'h20, 8'h20, 8'h20});
    finish_block("basic", 1'b0, 3'd3, 16'd0);

    // Extremes: 0xFF accumulates 65280, cand5 at 0xFE gives 16*16*254.
    send_rows(16, 8'h00, {8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    finish_block("max", 1'b0, 3'd5, 16'd65024);

    // Tie: every candidate off by one -> 256 each, index 0 wins.
    send_rows(16, 8'h11, {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10});
    finish_block("tie", 1'b0, 3'd0, 16'd256);

    // Gaps: 16 rows over 40 cycles, junk on the bus while valid_i is low and during CMP/DONE.
    busy_seen = 0;
    for (int r = 0; r < 16; r++) begin
      for (int g = 0; g < gaps[r]; g++) begin
        load(8'h00, {8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        if (busy === 1'b1) busy_seen++;
        tick();
      end
      if (busy === 1'b1) busy_seen++;
      send_rows(1, 8'h40, {8'h43, 8'h42, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49});
    end
    check("gaps busy during accum", busy_seen, 0);
    finish_block("gaps", 1'b1, 3'd6, 16'd512);

    // Reset at row 7 with valid_i high; the partial block favours cand2.
    send_rows(7, 8'h80, {8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'h80, 8'hD0, 8'hD0});
    load(8'h80, {8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'h80, 8'hD0, 8'hD0});
    valid = 1'b1;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    valid = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset best_idx", best_idx, 0);
    check("midreset best_sad", best_sad, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    check("midreset no done", done_seen, 0);
    send_rows(16, 8'h80, {8'h88, 8'h87, 8'h86, 8'h81, 8'h85, 8'h89, 8'h84, 8'h83});
    finish_block("fresh", 1'b0, 3'd4, 16'd256);

    // Back-to-back: block B starts in the cycle busy_o falls.
    send_rows(16, 8'h00, {8'h00, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    finish_block("b2b first", 1'b0, 3'd7, 16'd0);
    send_rows(16, 8'h00, {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h0F, 8'h10});
    finish_block("b2b second", 1'b0, 3'd1, 16'd3840);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
